// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Widest result the saturation generators can describe; callers truncate.
    localparam int unsigned MAX_W = 256;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    // Largest positive two's-complement value of the given width.
    function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
        return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value of the given width.
    function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
        return MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple of full adders; also exposes the carry into the MSB
// so the last stage can form the signed-overflow flag.
module rca_slice
    import rca_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o,
    output logic         c_msb_o
);

    logic [W:0] carry;

    // Ripple the carry LSB to MSB through W full adders.
    always_comb begin
        carry[0] = c_i;
        for (int i = 0; i < W; i++) begin
            s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = carry[W];
    assign c_msb_o = carry[W - 1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor with a global-stall valid/ready handshake.
// Each stage ripples one SLICE of the operands; the carry is registered between stages
// and the untouched upper operand bits are skewed forward alongside.
// Optional macro RCA_PIPE_SAT_EN: saturate the sum on signed overflow instead of wrapping.
module rca_pipe
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SLICE = slice_width(WIDTH, STAGES);
    localparam int unsigned LAST  = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_err
        $error("rca_pipe: STAGES must be in 1..WIDTH and divide WIDTH");
    end

`ifdef RCA_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SatMin = WIDTH'(sat_min(WIDTH));
`endif

    // Per-stage inputs (from the ports or the previous stage register).
    logic             v_in  [STAGES];
    logic             c_in  [STAGES];
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];

    // Per-stage slice results and next-state partial sums.
    logic [SLICE-1:0] sl_sum  [STAGES];
    logic             sl_c    [STAGES];
    logic             sl_cmsb [STAGES];
    logic [WIDTH-1:0] s_d     [STAGES];

    // Stage registers.
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] s_fin;

    logic advance;

    // Whole pipeline moves together; a held result freezes every stage.
    assign advance  = !v_q[LAST] | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] s_next;

        if (k == 0) begin : g_head
            // Subtraction is a + ~b + ~cin, so borrow-in becomes an inverted carry-in.
            assign v_in[0] = in_valid;
            assign a_in[0] = a;
            assign b_in[0] = (sub == MODE_SUB) ? ~b : b;
            assign c_in[0] = (sub == MODE_SUB) ? ~cin : cin;
            assign s_in[0] = '0;
        end else begin : g_link
            assign v_in[k] = v_q[k - 1];
            assign a_in[k] = a_q[k - 1];
            assign b_in[k] = b_q[k - 1];
            assign c_in[k] = c_q[k - 1];
            assign s_in[k] = s_q[k - 1];
        end

        rca_slice #(
            .W (SLICE)
        ) u_slice (
            .a_i     (a_in[k][k*SLICE +: SLICE]),
            .b_i     (b_in[k][k*SLICE +: SLICE]),
            .c_i     (c_in[k]),
            .s_o     (sl_sum[k]),
            .c_o     (sl_c[k]),
            .c_msb_o (sl_cmsb[k])
        );

        // Merge this stage's slice into the lower slices already produced.
        always_comb begin
            s_next                    = s_in[k];
            s_next[k*SLICE +: SLICE]  = sl_sum[k];
        end

        if (k == LAST) begin : g_tail
            assign s_d[k] = s_fin;
        end else begin : g_body
            assign s_d[k] = s_next;
        end

        // Stage register: cleared by reset, held whenever the pipeline is stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end else if (advance) begin
                v_q[k] <= v_in[k];
                c_q[k] <= sl_c[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    // Final-stage overflow and optional saturation; direction follows sign(a).
    always_comb begin
        ovf_d = sl_cmsb[LAST] ^ sl_c[LAST];
        s_fin = g_stage[LAST].s_next;
`ifdef RCA_PIPE_SAT_EN
        if (ovf_d) begin
            s_fin = a_in[LAST][WIDTH-1] ? SatMin : SatMax;
        end
`endif
    end

    // Overflow flag travels with the final stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe (WIDTH=32, STAGES=4): directed corner beats,
// backpressure, random streaming and mid-flight reset against an arithmetic model.
module tb_rca_pipe;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          acc_cyc;
        int          acc_stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_cnt = 0;
    exp_t q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_sum;
    logic        prev_cout;
    logic        prev_ovf;

    rca_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                   input logic ic, input logic is);
        exp_t   e;
        longint ua, ub, sa, sb, t, r;
        ua = longint'({32'd0, ia});
        ub = longint'({32'd0, ib});
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        if (!is) begin
            t   = ua + ub + longint'(ic);
            r   = sa + sb + longint'(ic);
            e.c = (t >= 64'sd4294967296);
        end else begin
            t   = ua - ub - longint'(ic);
            r   = sa - sb - longint'(ic);
            e.c = (t >= 0);
        end
        e.s = t[31:0];
        e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef RCA_PIPE_SAT_EN
        if (e.o) e.s = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.acc_cyc   = 0;
        e.acc_stall = 0;
        return e;
    endfunction

    // One clock: drive at negedge, check output handshake and hold, record accepts.
    task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input logic ic, input logic is, input logic ordy,
                         input logic use_exp, input logic [31:0] es, input logic ec,
                         input logic eo, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        cyc++;
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_sum", sum, prev_sum);
            chk("hold_cout", cout, prev_cout);
            chk("hold_ovf", ovf, prev_ovf);
        end
        chk("in_ready", in_ready, !out_valid || ordy);
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                chk("sum", sum, e.s);
                chk("cout", cout, e.c);
                chk("ovf", ovf, e.o);
                chk("latency", cyc - e.acc_cyc, STAGES + stall_cnt - e.acc_stall);
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e = model(ia, ib, ic, is);
            if (use_exp) begin
                e.s = es;
                e.c = ec;
                e.o = eo;
            end
            e.acc_cyc   = cyc;
            e.acc_stall = stall_cnt;
            q.push_back(e);
        end
        if (out_valid && !ordy) stall_cnt++;
        prev_stall = out_valid && !ordy;
        prev_sum   = sum;
        prev_cout  = cout;
        prev_ovf   = ovf;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        q.delete();
        prev_stall = 1'b0;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

`ifdef RCA_PIPE_SAT_EN
    localparam logic [31:0] PosOvfSum = 32'h7FFF_FFFF;
    localparam logic [31:0] NegOvfSum = 32'h8000_0000;
`else
    localparam logic [31:0] PosOvfSum = 32'h8000_0000;
    localparam logic [31:0] NegOvfSum = 32'h7FFF_FFFF;
`endif

    initial begin
        logic        acc;
        logic [31:0] ra, rb;
        logic        rc, rs;
        int          n_acc;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_sum", sum, 32'h0);
        chk("reset_cout", cout, 1'b0);
        chk("reset_ovf", ovf, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner beats, back to back, with hand-derived expectations.
        cycle(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1,
              1'b1, 32'h0000_0100, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1,
              1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1,
              1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1,
              1'b1, PosOvfSum, 1'b0, 1'b1, acc);
        cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1,
              1'b1, 32'h0000_0000, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1,
              1'b1, NegOvfSum, 1'b1, 1'b1, acc);
        cycle(1'b1, 32'h0000_000A, 32'h0000_000A, 1'b0, 1'b1, 1'b1,
              1'b1, 32'h0000_0000, 1'b1, 1'b0, acc);
        drain();

        // Eight back-to-back beats with a three-cycle output stall mid-stream.
        n_acc = 0;
        ra = $urandom;
        rb = $urandom;
        rc = 1'(($urandom) & 1);
        rs = 1'(($urandom) & 1);
        for (int i = 0; i < 40 && n_acc < 8; i++) begin
            cycle(1'b1, ra, rb, rc, rs, !(i >= 5 && i < 8), 1'b0, '0, 1'b0, 1'b0, acc);
            if (acc) begin
                n_acc++;
                ra = $urandom;
                rb = $urandom;
                rc = 1'(($urandom) & 1);
                rs = 1'(($urandom) & 1);
            end
        end
        chk("bp_accepted", n_acc, 8);
        drain();

        // Random streaming with random bubbles and backpressure.
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 9) < 8, rnd_op(), rnd_op(), 1'(($urandom) & 1),
                  1'(($urandom) & 1), $urandom_range(0, 3) != 0, 1'b0, '0, 1'b0, 1'b0, acc);
        end
        drain();

        // Reset with three beats in flight: nothing stale may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
            chk("flush_no_valid", out_valid, 1'b0);
        end
        cycle(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1,
              1'b1, 32'h2345_678A, 1'b0, 1'b0, acc);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
